// File: rtl/light_routine_sweeper_if.sv
// Bundle between the routine selector and the light-routine engine.
//   Enable : step prescaler run/freeze
//   Mode   : 00 bounce, 01 wrap, 10 fill, 11 hold
//   Leds   : LED pattern, bit 0 = leftmost LED
//   Digits : BCD step count, digit 0 in bits [3:0]
//   Done   : one-cycle completion pulse
// slave is the engine side, master is the selector side.
interface light_routine_sweeper_if #(
  parameter int unsigned LED_COUNT = 18,
  parameter int unsigned DIGITS    = 4
);
  logic                   Enable;
  logic [1:0]             Mode;
  logic [LED_COUNT-1:0]   Leds;
  logic [4*DIGITS-1:0]    Digits;
  logic                   Done;

  modport slave  (input Enable, input Mode, output Leds, output Digits, output Done);
  modport master (output Enable, output Mode, input Leds, input Digits, input Done);
endinterface

// File: rtl/light_routine_sweeper.sv
// LED light-routine engine: bounce/wrap bar, fill pattern or hold on an LED strip,
// a BCD step counter for the seven-segment decoders, and a Done pulse every
// SWEEPS completed sweeps.
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high
//   bus   : light_routine_sweeper_if.slave (Enable, Mode in; Leds, Digits, Done out)
module light_routine_sweeper #(
  parameter int unsigned LED_COUNT = 18,
  parameter int unsigned BAR_WIDTH = 4,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned STEP_DIV  = 1,
  parameter int unsigned SWEEPS    = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  light_routine_sweeper_if.slave  bus
);

  localparam int unsigned Max  = LED_COUNT - BAR_WIDTH;
  localparam int unsigned PosW = $clog2(LED_COUNT + 1);
  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned CntW = $clog2(SWEEPS + 1);

  localparam logic [PosW-1:0] MaxPos    = PosW'(Max);
  localparam logic [PosW-1:0] FullFill  = PosW'(LED_COUNT);
  localparam logic [DivW-1:0] DivLast   = DivW'(STEP_DIV - 1);
  localparam logic [CntW-1:0] SweepLast = CntW'(SWEEPS - 1);

  typedef enum logic [1:0] {
    ModeBounce = 2'b00,
    ModeWrap   = 2'b01,
    ModeFill   = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  function automatic logic [LED_COUNT-1:0] bar_pattern(input logic [PosW-1:0] p);
    logic [LED_COUNT-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LED_COUNT); i++) begin
      r[i] = (i >= int'(p)) && (i < int'(p) + int'(BAR_WIDTH));
    end
    return r;
  endfunction

  function automatic logic [LED_COUNT-1:0] fill_pattern(input logic [PosW-1:0] f);
    logic [LED_COUNT-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LED_COUNT); i++) begin
      r[i] = i < int'(f);
    end
    return r;
  endfunction

  logic [DivW-1:0]      presc_q;
  mode_e                mode_q;
  logic [PosW-1:0]      pos_q, pos_nx;
  logic                 dir_up_q, dir_up_nx;
  logic [PosW-1:0]      fill_q, fill_nx;
  logic [CntW-1:0]      sweep_q;
  logic [LED_COUNT-1:0] leds_q;
  logic [4*DIGITS-1:0]  digits_q, digits_nx;
  logic                 done_q;
  logic                 strobe;
  logic                 wrap;
  logic                 carry;
  logic [3:0]           dig;
  mode_e                mode_in;

  assign mode_in = mode_e'(bus.Mode);
  assign strobe  = bus.Enable && (presc_q == DivLast);

  // Pattern advance for the current mode; wrap marks a completed sweep.
  always_comb begin
    pos_nx    = pos_q;
    dir_up_nx = dir_up_q;
    fill_nx   = fill_q;
    wrap      = 1'b0;
    unique case (mode_q)
      ModeBounce: begin
        if (dir_up_q) begin
          // Still heading up at MAX only happens when MAX is 0.
          if (pos_q == MaxPos) begin
            wrap = 1'b1;
          end else begin
            pos_nx = pos_q + 1'b1;
            if (pos_nx == MaxPos) dir_up_nx = 1'b0;
          end
        end else begin
          if (pos_q != '0) pos_nx = pos_q - 1'b1;
          if (pos_nx == '0) begin
            dir_up_nx = 1'b1;
            wrap      = 1'b1;
          end
        end
      end
      ModeWrap: begin
        if (pos_q == MaxPos) begin
          pos_nx = '0;
          wrap   = 1'b1;
        end else begin
          pos_nx = pos_q + 1'b1;
        end
      end
      ModeFill: begin
        if (fill_q == FullFill) begin
          fill_nx = '0;
          wrap    = 1'b1;
        end else begin
          fill_nx = fill_q + 1'b1;
        end
      end
      ModeHold: ;
    endcase
  end

  // Ripple-carry BCD increment; all nines wraps to all zeros.
  always_comb begin
    digits_nx = digits_q;
    carry     = 1'b1;
    dig       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = digits_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          digits_nx[4*i +: 4] = 4'd0;
        end else begin
          digits_nx[4*i +: 4] = dig + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc_q  <= '0;
      mode_q   <= ModeBounce;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      fill_q   <= '0;
      sweep_q  <= '0;
      leds_q   <= bar_pattern('0);
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.Enable) presc_q <= strobe ? '0 : presc_q + 1'b1;
      if (strobe) begin
        digits_q <= digits_nx;
        if (mode_in != mode_q) begin
          mode_q   <= mode_in;
          pos_q    <= '0;
          dir_up_q <= 1'b1;
          fill_q   <= '0;
          sweep_q  <= '0;
          unique case (mode_in)
            ModeBounce, ModeWrap: leds_q <= bar_pattern('0);
            ModeFill:             leds_q <= '0;
            ModeHold:             ;
          endcase
        end else begin
          pos_q    <= pos_nx;
          dir_up_q <= dir_up_nx;
          fill_q   <= fill_nx;
          unique case (mode_q)
            ModeBounce, ModeWrap: leds_q <= bar_pattern(pos_nx);
            ModeFill:             leds_q <= fill_pattern(fill_nx);
            ModeHold:             ;
          endcase
          if (wrap) begin
            if (sweep_q == SweepLast) begin
              sweep_q <= '0;
              done_q  <= 1'b1;
            end else begin
              sweep_q <= sweep_q + 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.Leds   = leds_q;
  assign bus.Digits = digits_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_light_routine_sweeper.sv
module tb_light_routine_sweeper;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  light_routine_sweeper_if #(.LED_COUNT(18), .DIGITS(4)) if_a ();
  light_routine_sweeper_if #(.LED_COUNT(6),  .DIGITS(2)) if_b ();
  light_routine_sweeper_if #(.LED_COUNT(3),  .DIGITS(4)) if_c ();

  light_routine_sweeper #(
    .LED_COUNT(18), .BAR_WIDTH(4), .DIGITS(4), .STEP_DIV(1), .SWEEPS(1)
  ) dut_a (.Clock(clk), .Reset(rst), .bus(if_a));

  light_routine_sweeper #(
    .LED_COUNT(6), .BAR_WIDTH(2), .DIGITS(2), .STEP_DIV(3), .SWEEPS(3)
  ) dut_b (.Clock(clk), .Reset(rst), .bus(if_b));

  light_routine_sweeper #(
    .LED_COUNT(3), .BAR_WIDTH(3), .DIGITS(4), .STEP_DIV(1), .SWEEPS(2)
  ) dut_c (.Clock(clk), .Reset(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        chk_leds;
    logic [17:0] leds;
    logic [15:0] digits;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r = {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    return r;
  endfunction

  function automatic logic [17:0] bar18(input int p);
    logic [31:0] r;
    r = 32'hF << p;
    return r[17:0];
  endfunction

  function automatic logic [17:0] fill18(input int f);
    logic [31:0] r;
    r = (32'd1 << f) - 32'd1;
    return r[17:0];
  endfunction

  function automatic void add(input logic en, input logic [1:0] mode, input logic chk,
                              input logic [17:0] leds, input int step, input logic done);
    vec_t v;
    v.en = en; v.mode = mode; v.chk_leds = chk; v.leds = leds;
    v.digits = bcd(step); v.done = done;
    vecs.push_back(v);
  endfunction

  initial begin
    int p;
    int d;
    int m;
    logic exp_done;
    logic [7:0] exp_leds_b;
    logic [1:0] mode_b;
    logic done_c [7];
    logic [1:0] mode_c [7];

    n_total = 0;
    n_pass  = 0;

    // Table for instance A: one vector per cycle, STEP_DIV=1 so each is a step.
    for (int k = 1; k <= 29; k++) begin
      p = (k <= 14) ? k : ((k <= 28) ? 28 - k : k - 28);
      add(1'b1, 2'b00, 1'b1, bar18(p), k, k == 28);
    end
    add(1'b1, 2'b11, 1'b0, 18'h0, 30, 1'b0);
    add(1'b1, 2'b11, 1'b1, 18'h0001E, 31, 1'b0);
    add(1'b1, 2'b11, 1'b1, 18'h0001E, 32, 1'b0);
    add(1'b1, 2'b10, 1'b1, 18'h00000, 33, 1'b0);
    for (int k = 34; k <= 52; k++) begin
      d = k - 33;
      add(1'b1, 2'b10, 1'b1, (d <= 18) ? fill18(d) : 18'h0, k, k == 52);
    end
    add(1'b0, 2'b10, 1'b1, 18'h0, 52, 1'b0);
    add(1'b0, 2'b10, 1'b1, 18'h0, 52, 1'b0);
    add(1'b1, 2'b00, 1'b1, 18'h0000F, 53, 1'b0);
    for (int k = 54; k <= 74; k++) begin
      p = (k <= 67) ? k - 53 : 14 - (k - 67);
      add(1'b1, 2'b00, 1'b1, bar18(p), k, 1'b0);
    end

    rst = 1'b1;
    if_a.Enable = 1'b0; if_a.Mode = 2'b00;
    if_b.Enable = 1'b0; if_b.Mode = 2'b00;
    if_c.Enable = 1'b0; if_c.Mode = 2'b00;
    #12;
    check("a_reset_leds", 32'(if_a.Leds), 32'h0000F);
    check("a_reset_digits", 32'(if_a.Digits), 32'h0);
    check("a_reset_done", 32'(if_a.Done), 32'h0);
    check("b_reset_leds", 32'(if_b.Leds), 32'h03);
    check("c_reset_leds", 32'(if_c.Leds), 32'h7);
    rst = 1'b0;

    // Instance A: table-driven run.
    for (int i = 0; i < vecs.size(); i++) begin
      if_a.Enable = vecs[i].en;
      if_a.Mode   = vecs[i].mode;
      tick();
      if (vecs[i].chk_leds) check($sformatf("a_leds[%0d]", i), 32'(if_a.Leds), 32'(vecs[i].leds));
      check($sformatf("a_digits[%0d]", i), 32'(if_a.Digits), 32'(vecs[i].digits));
      check($sformatf("a_done[%0d]", i), 32'(if_a.Done), 32'(vecs[i].done));
    end

    // Instance A now at pos 7 heading down: asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    check("a_async_leds", 32'(if_a.Leds), 32'h0000F);
    check("a_async_digits", 32'(if_a.Digits), 32'h0);
    check("a_async_done", 32'(if_a.Done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("a_restart1_leds", 32'(if_a.Leds), 32'h0001E);
    check("a_restart1_digits", 32'(if_a.Digits), 32'h1);
    tick();
    check("a_restart2_leds", 32'(if_a.Leds), 32'h0003C);
    check("a_restart2_digits", 32'(if_a.Digits), 32'h2);
    if_a.Enable = 1'b0;

    // Instance B: STEP_DIV=3, SWEEPS=3, MAX=4.
    if_b.Mode   = 2'b01;
    if_b.Enable = 1'b1;
    tick(); tick();
    check("b_prestrobe_digits", 32'(if_b.Digits), 32'h00);
    tick();
    check("b_step1_digits", 32'(if_b.Digits), 32'h01);
    check("b_step1_leds", 32'(if_b.Leds), 32'h03);
    tick();
    if_b.Enable = 1'b0;
    repeat (5) tick();
    check("b_gap_digits", 32'(if_b.Digits), 32'h01);
    if_b.Enable = 1'b1;
    tick();
    check("b_resume_digits", 32'(if_b.Digits), 32'h01);
    tick();
    check("b_step2_digits", 32'(if_b.Digits), 32'h02);
    check("b_step2_leds", 32'(if_b.Leds), 32'h06);

    for (int s = 3; s <= 100; s++) begin
      if (s <= 23) begin
        exp_leds_b = 8'(8'h3 << ((s - 1) % 5));
      end else begin
        m = (s - 24) % 8;
        p = (m <= 4) ? m : 8 - m;
        exp_leds_b = 8'(8'h3 << p);
      end
      for (int t = 0; t < 3; t++) begin
        mode_b = (s <= 23) ? 2'b01 : 2'b00;
        if (s == 23 && t < 2) mode_b = 2'b10;
        if_b.Mode = mode_b;
        tick();
        exp_done = (t == 2) && (s == 16 || s == 48 || s == 72 || s == 96);
        check($sformatf("b_done[s%0d,t%0d]", s, t), 32'(if_b.Done), 32'(exp_done));
        if (t == 2) begin
          check($sformatf("b_leds[s%0d]", s), 32'(if_b.Leds), 32'(exp_leds_b));
          check($sformatf("b_digits[s%0d]", s), 32'(if_b.Digits), 32'(bcd(s % 100)));
        end
      end
    end
    if_b.Enable = 1'b0;

    // Instance C: MAX=0, every bounce/wrap step completes; SWEEPS=2.
    done_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mode_c = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    if_c.Enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if_c.Mode = mode_c[i];
      tick();
      check($sformatf("c_done[%0d]", i), 32'(if_c.Done), 32'(done_c[i]));
      check($sformatf("c_leds[%0d]", i), 32'(if_c.Leds), 32'h7);
    end
    if_c.Enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
